// File: rtl/rv32e_fetch_decode_exec_if.sv
// Bundle between the fetch/decode/execute block and the external PC
// register, register file, instruction memory and data memory.
interface rv32e_fetch_decode_exec_if #(
  parameter int RF_ADDR_W = 4
);
  logic [31:0]          pc;
  logic [31:0]          imem_addr;
  logic [31:0]          imem_rdata;
  logic [31:0]          inst;
  logic [RF_ADDR_W-1:0] rs1;
  logic [RF_ADDR_W-1:0] rs2;
  logic [31:0]          rf_rdata1;
  logic [31:0]          rf_rdata2;
  logic [RF_ADDR_W-1:0] rd;
  logic                 rf_wen;
  logic [31:0]          rf_wdata;
  logic [31:0]          dmem_addr;
  logic                 dmem_ren;
  logic                 dmem_wen;
  logic [3:0]           dmem_wmask;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  logic [31:0]          pc_next;
  logic                 ebreak;
  logic                 illegal;
  logic                 halted;

  // Core side: consumes pc/read data, produces controls.
  modport master (
    input  pc, imem_rdata, rf_rdata1, rf_rdata2, dmem_rdata,
    output imem_addr, inst, rs1, rs2, rd, rf_wen, rf_wdata,
           dmem_addr, dmem_ren, dmem_wen, dmem_wmask, dmem_wdata,
           pc_next, ebreak, illegal, halted
  );

  // Environment side: PC register, register file and memories.
  modport slave (
    output pc, imem_rdata, rf_rdata1, rf_rdata2, dmem_rdata,
    input  imem_addr, inst, rs1, rs2, rd, rf_wen, rf_wdata,
           dmem_addr, dmem_ren, dmem_wen, dmem_wmask, dmem_wdata,
           pc_next, ebreak, illegal, halted
  );
endinterface

// File: rtl/rv32e_fetch_decode_exec.sv
// Single-cycle RV32E/RV32I fetch, decode and execute datapath.
// Everything is combinational except the sticky halted flag, which is set
// by EBREAK or an unsupported encoding and only cleared by reset.
module rv32e_fetch_decode_exec #(
  parameter int RF_ADDR_W = 4
) (
  input  logic clk,
  input  logic rst,
  rv32e_fetch_decode_exec_if.master bus
);
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_OP    = 7'h33;
  // Register-index bits that must be zero for the configured file size.
  localparam logic [4:0] IDX_HI   = 5'h1F << RF_ADDR_W;

  logic [31:0] inst, pc, a, b, alu_b, alu_res, sra_res, load_val, wdata_c;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, ld_addr, st_addr, mem_addr, target;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  shamt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        legal, use_rs1, use_rs2, use_rd, wb, is_load, is_store, is_branch;
  logic        is_jal, is_jalr, alu_imm, alu_alt, taken, idx_bad;
  logic        ebreak_d, illegal_d, active, halted_q;

  assign pc     = bus.pc;
  assign inst   = bus.imem_rdata;
  assign a      = bus.rf_rdata1;
  assign b      = bus.rf_rdata2;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Classify the instruction and decide which operands it touches.
  always_comb begin
    legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; wb = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jal = 1'b0;
    is_jalr = 1'b0; alu_imm = 1'b0; alu_alt = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin legal = 1'b1; use_rd = 1'b1; wb = 1'b1; end
      OP_JAL:  begin legal = 1'b1; use_rd = 1'b1; wb = 1'b1; is_jal = 1'b1; end
      OP_JALR: begin
        legal = (funct3 == 3'b000); use_rs1 = 1'b1; use_rd = 1'b1; wb = 1'b1; is_jalr = 1'b1;
      end
      OP_BR: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1;
      end
      OP_LD: begin
        legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        use_rs1 = 1'b1; use_rd = 1'b1; wb = 1'b1; is_load = 1'b1;
      end
      OP_ST: begin
        legal = (funct3 inside {3'b000, 3'b001, 3'b010});
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
      end
      OP_IMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1; wb = 1'b1; alu_imm = 1'b1;
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  begin legal = (funct7 == 7'h00) || (funct7 == 7'h20); alu_alt = funct7[5]; end
          default: legal = 1'b1;
        endcase
      end
      OP_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; wb = 1'b1;
        legal = (funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        alu_alt = funct7[5];
      end
      default: legal = 1'b0;
    endcase
  end

  assign idx_bad   = (use_rs1 && |(inst[19:15] & IDX_HI)) ||
                     (use_rs2 && |(inst[24:20] & IDX_HI)) ||
                     (use_rd  && |(inst[11:7]  & IDX_HI));
  assign ebreak_d  = (inst == 32'h0010_0073);
  assign illegal_d = !ebreak_d && !(legal && !idx_bad);
  assign active    = !halted_q && !illegal_d && !ebreak_d;

  // alu_alt is only set for SUB, SRA and SRAI, so ADDI never subtracts.
  assign alu_b   = alu_imm ? imm_i : b;
  assign shamt   = alu_b[4:0];
  assign sra_res = $signed(a) >>> shamt;

  // Integer ALU shared by OP and OP-IMM.
  always_comb begin
    alu_res = 32'b0;
    case (funct3)
      3'b000: alu_res = alu_alt ? a - alu_b : a + alu_b;
      3'b001: alu_res = a << shamt;
      3'b010: alu_res = {31'b0, $signed(a) < $signed(alu_b)};
      3'b011: alu_res = {31'b0, a < alu_b};
      3'b100: alu_res = a ^ alu_b;
      3'b101: alu_res = alu_alt ? sra_res : a >> shamt;
      3'b110: alu_res = a | alu_b;
      3'b111: alu_res = a & alu_b;
      default: alu_res = 32'b0;
    endcase
  end

  // Branch condition.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = $signed(a) < $signed(b);
      3'b101:  taken = $signed(a) >= $signed(b);
      3'b110:  taken = a < b;
      3'b111:  taken = a >= b;
      default: taken = 1'b0;
    endcase
  end

  assign ld_addr  = a + imm_i;
  assign st_addr  = a + imm_s;
  assign mem_addr = is_store ? st_addr : ld_addr;
  assign ld_byte  = bus.dmem_rdata[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_half  = bus.dmem_rdata[{mem_addr[1], 4'b0000} +: 16];

  // Load extension and store lane steering; addresses are never trapped.
  always_comb begin
    load_val = bus.dmem_rdata;
    case (funct3)
      3'b000: load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001: load_val = {{16{ld_half[15]}}, ld_half};
      3'b100: load_val = {24'b0, ld_byte};
      3'b101: load_val = {16'b0, ld_half};
      default: load_val = bus.dmem_rdata;
    endcase
    bus.dmem_wmask = 4'b0000;
    bus.dmem_wdata = b;
    case (funct3)
      3'b000: begin
        bus.dmem_wmask = 4'b0001 << mem_addr[1:0];
        bus.dmem_wdata = {4{b[7:0]}};
      end
      3'b001: begin
        bus.dmem_wmask = mem_addr[1] ? 4'b1100 : 4'b0011;
        bus.dmem_wdata = {2{b[15:0]}};
      end
      default: bus.dmem_wmask = 4'b1111;
    endcase
    if (!(is_store && active)) bus.dmem_wmask = 4'b0000;
  end

  // Writeback data and next-PC selection.
  always_comb begin
    wdata_c = alu_res;
    target  = pc + 32'd4;
    if (opcode == OP_LUI)        wdata_c = imm_u;
    else if (opcode == OP_AUIPC) wdata_c = pc + imm_u;
    else if (is_jal || is_jalr)  wdata_c = pc + 32'd4;
    else if (is_load)            wdata_c = load_val;
    if (is_jal)                  target = pc + imm_j;
    else if (is_jalr)            target = ld_addr & ~32'd1;
    else if (is_branch && taken) target = pc + imm_b;
  end

  assign bus.imem_addr = pc;
  assign bus.inst      = inst;
  assign bus.rs1       = inst[15 +: RF_ADDR_W];
  assign bus.rs2       = inst[20 +: RF_ADDR_W];
  assign bus.rd        = inst[7 +: RF_ADDR_W];
  assign bus.rf_wen    = wb && active && (inst[11:7] != 5'd0);
  assign bus.rf_wdata  = wdata_c;
  assign bus.dmem_addr = mem_addr;
  assign bus.dmem_ren  = is_load && active;
  assign bus.dmem_wen  = is_store && active;
  assign bus.pc_next   = active ? target : pc;
  assign bus.ebreak    = ebreak_d;
  assign bus.illegal   = illegal_d;
  assign bus.halted    = halted_q;

  // Sticky halt: set after EBREAK/illegal, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        halted_q <= 1'b0;
    else if (ebreak_d || illegal_d) halted_q <= 1'b1;
  end
endmodule

// File: tb/tb_rv32e_fetch_decode_exec.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor
// pops and compares them against the combinational outputs.
module tb_rv32e_fetch_decode_exec;
  localparam int W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32e_fetch_decode_exec_if #(.RF_ADDR_W(W)) bus ();
  rv32e_fetch_decode_exec #(.RF_ADDR_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum {I_LUI, I_AUIPC, I_JAL, I_JALR, I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
                I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW,
                I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
                I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
                I_EBREAK, I_BAD} mn_t;

  typedef struct {
    logic [31:0] inst, pc;
    logic [3:0]  rs1, rs2, rd;
    logic        wen, wb_chk, mem_chk, ren, dwen, ebreak, illegal, halted;
    logic [31:0] wdata, addr, dwdata, pc_next;
    logic [3:0]  mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic halted_m = 1'b0;
  logic pending = 1'b0;

  function automatic mn_t decode(input logic [31:0] i);
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    if (i == 32'h0010_0073) return I_EBREAK;
    case (i[6:0])
      7'h37: return I_LUI;
      7'h17: return I_AUIPC;
      7'h6F: return I_JAL;
      7'h67: return (f3 == 3'd0) ? I_JALR : I_BAD;
      7'h63: case (f3)
        3'd0: return I_BEQ;  3'd1: return I_BNE;  3'd4: return I_BLT;
        3'd5: return I_BGE;  3'd6: return I_BLTU; 3'd7: return I_BGEU;
        default: return I_BAD;
      endcase
      7'h03: case (f3)
        3'd0: return I_LB; 3'd1: return I_LH; 3'd2: return I_LW;
        3'd4: return I_LBU; 3'd5: return I_LHU;
        default: return I_BAD;
      endcase
      7'h23: case (f3)
        3'd0: return I_SB; 3'd1: return I_SH; 3'd2: return I_SW;
        default: return I_BAD;
      endcase
      7'h13: case (f3)
        3'd0: return I_ADDI; 3'd2: return I_SLTI; 3'd3: return I_SLTIU;
        3'd4: return I_XORI; 3'd6: return I_ORI;  3'd7: return I_ANDI;
        3'd1: return (f7 == 7'h00) ? I_SLLI : I_BAD;
        default: return (f7 == 7'h00) ? I_SRLI : (f7 == 7'h20) ? I_SRAI : I_BAD;
      endcase
      7'h33: case ({f7, f3})
        {7'h00, 3'd0}: return I_ADD;  {7'h20, 3'd0}: return I_SUB;
        {7'h00, 3'd1}: return I_SLL;  {7'h00, 3'd2}: return I_SLT;
        {7'h00, 3'd3}: return I_SLTU; {7'h00, 3'd4}: return I_XOR;
        {7'h00, 3'd5}: return I_SRL;  {7'h20, 3'd5}: return I_SRA;
        {7'h00, 3'd6}: return I_OR;   {7'h00, 3'd7}: return I_AND;
        default: return I_BAD;
      endcase
      default: return I_BAD;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] i, pc, a, b, dr, input logic h);
    exp_t e;
    mn_t m;
    logic signed [31:0] si, sa, sgn, t;
    logic [31:0] ii, is, ib, iu, ij, res, tgt, byt, hw;
    logic writes, u1, u2, st, ld, act;
    int off, sh;
    m  = decode(i);
    si = i;
    sa = a;
    ii = si >>> 20;
    t  = si >>> 25;
    is = (t << 5) + 32'(i[11:7]);
    sgn = si >>> 31;
    ib = (sgn << 12) + (32'(i[7]) << 11) + (32'(i[30:25]) << 5) + (32'(i[11:8]) << 1);
    iu = i & 32'hFFFF_F000;
    ij = (sgn << 20) + (32'(i[19:12]) << 12) + (32'(i[20]) << 11) + (32'(i[30:21]) << 1);
    ld = m inside {I_LB, I_LH, I_LW, I_LBU, I_LHU};
    st = m inside {I_SB, I_SH, I_SW};
    writes = !(st || (m inside {I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU, I_EBREAK, I_BAD}));
    u1 = !(m inside {I_LUI, I_AUIPC, I_JAL, I_EBREAK, I_BAD});
    u2 = st || (m inside {I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU, I_ADD, I_SUB, I_SLL,
                          I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND});
    e.addr = st ? a + is : a + ii;
    off = int'(e.addr % 4);
    byt = (dr >> (8 * off)) & 32'hFF;
    hw  = (dr >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    sh  = (m inside {I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI})
          ? int'(ii % 32) : int'(b % 32);
    res = 32'd0;
    tgt = pc + 4;
    case (m)
      I_LUI:   res = iu;
      I_AUIPC: res = pc + iu;
      I_JAL:   begin res = pc + 4; tgt = pc + ij; end
      I_JALR:  begin res = pc + 4; tgt = (a + ii) & 32'hFFFF_FFFE; end
      I_BEQ:   if (a == b) tgt = pc + ib;
      I_BNE:   if (a != b) tgt = pc + ib;
      I_BLT:   if ($signed(a) < $signed(b)) tgt = pc + ib;
      I_BGE:   if ($signed(a) >= $signed(b)) tgt = pc + ib;
      I_BLTU:  if (a < b) tgt = pc + ib;
      I_BGEU:  if (a >= b) tgt = pc + ib;
      I_LB:    res = (byt >= 128) ? byt - 256 : byt;
      I_LH:    res = (hw >= 32768) ? hw - 65536 : hw;
      I_LW:    res = dr;
      I_LBU:   res = byt;
      I_LHU:   res = hw;
      I_ADDI:  res = a + ii;
      I_SLTI:  res = ($signed(a) < $signed(ii)) ? 1 : 0;
      I_SLTIU: res = (a < ii) ? 1 : 0;
      I_XORI:  res = a ^ ii;
      I_ORI:   res = a | ii;
      I_ANDI:  res = a & ii;
      I_SLLI, I_SLL: res = a << sh;
      I_SRLI, I_SRL: res = a >> sh;
      I_SRAI, I_SRA: begin t = sa >>> sh; res = t; end
      I_ADD:   res = a + b;
      I_SUB:   res = a - b;
      I_SLT:   res = ($signed(a) < $signed(b)) ? 1 : 0;
      I_SLTU:  res = (a < b) ? 1 : 0;
      I_XOR:   res = a ^ b;
      I_OR:    res = a | b;
      I_AND:   res = a & b;
      default: res = 32'd0;
    endcase
    e.inst    = i;
    e.pc      = pc;
    e.rs1     = i[18:15];
    e.rs2     = i[23:20];
    e.rd      = i[10:7];
    e.ebreak  = (m == I_EBREAK);
    e.illegal = (m == I_BAD) || (u1 && i[19]) || (u2 && i[24]) || (writes && i[11]);
    e.halted  = h;
    act       = !h && !e.illegal && !e.ebreak;
    e.wb_chk  = writes && !e.illegal;
    e.wdata   = res;
    e.wen     = act && writes && (i[11:7] != 0);
    e.mem_chk = ld || st;
    e.ren     = act && ld;
    e.dwen    = act && st;
    e.mask    = 4'b0000;
    e.dwdata  = b;
    if (e.dwen) begin
      if (m == I_SB)      begin e.mask = 4'(1 << off); e.dwdata = (b & 32'hFF) * 32'h0101_0101; end
      else if (m == I_SH) begin e.mask = (off >= 2) ? 4'hC : 4'h3; e.dwdata = (b & 32'hFFFF) * 32'h0001_0001; end
      else                e.mask = 4'hF;
    end
    e.pc_next = act ? tgt : pc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%h: got %h, expected %h", name, inst, act, exp);
    end
  endtask

  // Monitor: compare each presented response against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr", e.inst, bus.imem_addr, e.pc);
      chk("inst",      e.inst, bus.inst, e.inst);
      chk("rs1",       e.inst, 32'(bus.rs1), 32'(e.rs1));
      chk("rs2",       e.inst, 32'(bus.rs2), 32'(e.rs2));
      chk("rd",        e.inst, 32'(bus.rd), 32'(e.rd));
      chk("rf_wen",    e.inst, 32'(bus.rf_wen), 32'(e.wen));
      chk("dmem_ren",  e.inst, 32'(bus.dmem_ren), 32'(e.ren));
      chk("dmem_wen",  e.inst, 32'(bus.dmem_wen), 32'(e.dwen));
      chk("dmem_wmask", e.inst, 32'(bus.dmem_wmask), 32'(e.mask));
      chk("pc_next",   e.inst, bus.pc_next, e.pc_next);
      chk("ebreak",    e.inst, 32'(bus.ebreak), 32'(e.ebreak));
      chk("illegal",   e.inst, 32'(bus.illegal), 32'(e.illegal));
      chk("halted",    e.inst, 32'(bus.halted), 32'(e.halted));
      if (e.wb_chk)  chk("rf_wdata",   e.inst, bus.rf_wdata, e.wdata);
      if (e.mem_chk) chk("dmem_addr",  e.inst, bus.dmem_addr, e.addr);
      if (e.dwen)    chk("dmem_wdata", e.inst, bus.dmem_wdata, e.dwdata);
    end
  end

  // One stimulus cycle; with do_rst the reset is pulsed mid-cycle.
  task automatic apply(input logic [31:0] i, pc, a, b, dr, input logic do_rst);
    exp_t e;
    @(posedge clk);
    if (pending && !rst) halted_m = 1'b1;
    pending = 1'b0;
    #1;
    if (do_rst) begin
      rst = 1'b1;
      halted_m = 1'b0;
    end
    bus.imem_rdata = i;
    bus.pc         = pc;
    bus.rf_rdata1  = a;
    bus.rf_rdata2  = b;
    bus.dmem_rdata = dr;
    e = model(i, pc, a, b, dr, halted_m);
    q.push_back(e);
    pending = e.ebreak || e.illegal;
    if (do_rst) begin
      @(negedge clk);
      #1 rst = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 40));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
      2: return 32'h8000_0000 + 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 99);
    logic [6:0] f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (k < 3) return 32'h0010_0073;
    if (k < 5) return w;
    w[6:0] = ops[$urandom_range(0, 8)];
    if (k < 92) begin w[19] = 1'b0; w[24] = 1'b0; w[11] = 1'b0; end
    if (k < 96) begin
      if (w[6:0] == 7'h67) w[14:12] = 3'd0;
      if (w[6:0] == 7'h13 && w[14:12] == 3'd1) w[31:25] = 7'h00;
      if (w[6:0] == 7'h13 && w[14:12] == 3'd5) w[31:25] = f7;
      if (w[6:0] == 7'h33) w[31:25] = (w[14:12] == 3'd0 || w[14:12] == 3'd5) ? f7 : 7'h00;
    end
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_rdata = NOP;
    bus.pc = 32'h8000_0000;
    bus.rf_rdata1 = 32'd0;
    bus.rf_rdata2 = 32'd0;
    bus.dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    apply(NOP,           32'h8000_0000, 32'd0,         32'd0,   32'd0,         1'b1);
    apply(32'h00500093,  32'h8000_0000, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(32'h008000EF,  32'h8000_0000, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(32'h00000863,  32'h8000_0000, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(32'h00108103,  32'h8000_0000, 32'h8000_0100, 32'd0,   32'h0000_8000, 1'b0);
    apply(32'h0010C103,  32'h8000_0000, 32'h8000_0100, 32'd0,   32'h0000_8000, 1'b0);
    apply(32'h002081A3,  32'h8000_0000, 32'h8000_0100, 32'hAB,  32'd0,         1'b0);
    apply(32'h00100073,  32'h8000_0010, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(32'h00500093,  32'h8000_0010, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(32'h00500093,  32'h8000_0010, 32'd0,         32'd0,   32'd0,         1'b1);
    apply(32'h00000000,  32'h8000_0020, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(NOP,           32'h8000_0024, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(NOP,           32'h8000_0024, 32'd0,         32'd0,   32'd0,         1'b1);
    apply(32'h00100813,  32'h8000_0028, 32'd0,         32'd0,   32'd0,         1'b0);
    apply(NOP,           32'h8000_002C, 32'd0,         32'd0,   32'd0,         1'b1);
    for (int n = 0; n < 400; n++) begin
      apply(rand_inst(), $urandom & 32'hFFFF_FFFC, rand_data(), rand_data(), $urandom, 1'b0);
      if (pending) begin
        apply(rand_inst(), $urandom & 32'hFFFF_FFFC, rand_data(), rand_data(), $urandom, 1'b0);
        apply(NOP, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b1);
      end
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'd0, 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32e_fetch_decode_exec.md
Name: rv32e_fetch_decode_exec

Overview:
- Single-cycle RV32E fetch/decode/execute datapath (IFU+IDU+EXU) of the ysyx_24110015 core.
- The PC register and register file are external. This block takes the current pc and register read data and produces:
  - pc_next
  - register writeback controls
  - data-memory controls
  - ebreak/illegal signalling
- Holds one piece of state: a sticky halted flag.

Parameters:
- RF_ADDR_W, 4, register index width. 4 means RV32E (x0..x15); 5 means RV32I.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc  in  32  current PC from the external PC register.
- imem_addr  out  32  instruction fetch address; equals pc.
- imem_rdata  in  32  instruction word; combinational read.
- inst  out  32  fetched instruction; equals imem_rdata.
- rs1  out  RF_ADDR_W  inst[15+:RF_ADDR_W].
- rs2  out  RF_ADDR_W  inst[20+:RF_ADDR_W].
- rf_rdata1  in  32  value of rs1.
- rf_rdata2  in  32  value of rs2.
- rd  out  RF_ADDR_W  inst[7+:RF_ADDR_W].
- rf_wen  out  1  register write enable.
- rf_wdata  out  32  register write data.
- dmem_addr  out  32  data address, rs1+imm.
- dmem_ren  out  1  load strobe.
- dmem_wen  out  1  store strobe.
- dmem_wmask  out  4  byte-lane write mask.
- dmem_wdata  out  32  store data, lane-aligned.
- dmem_rdata  in  32  word read at {dmem_addr[31:2],2'b00}; combinational.
- pc_next  out  32  next PC, sampled by the external PC register.
- ebreak  out  1  current instruction is EBREAK (0x00100073).
- illegal  out  1  current instruction is unsupported.
- halted  out  1  sticky halt flag.

Behaviour:
- All datapath logic is combinational. The only register is halted.
- Reset: halted=0. All other outputs are a pure function of the inputs.
- Decode: opcode=inst[6:0], funct3=inst[14:12], funct7=inst[31:25].
- Immediates, all sign-extended from inst[31]: I, S, B, U, J formats per RV32I.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR
  - BEQ, BNE, BLT, BGE, BLTU, BGEU
  - LB, LH, LW, LBU, LHU
  - SB, SH, SW
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - EBREAK
- illegal=1 for any of:
  - any other encoding;
  - a shift-immediate or OP instruction with a funct7 other than 0000000, or 0100000 where permitted (SUB, SRA, SRAI);
  - any used register index with bits above RF_ADDR_W-1 set.
- ALU operations:
  - Shifts use the low 5 bits of the operand.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - Arithmetic wraps modulo 2^32.
- Writeback data:
  - LUI: immU.
  - AUIPC: pc+immU.
  - JAL/JALR: pc+4.
  - Loads: extended load data.
  - OP/OP-IMM: ALU result.
- rf_wen=1 only for writeback instructions with rd!=0, when not illegal, not ebreak and not halted.
- pc_next:
  - Default: pc+4.
  - JAL: pc+immJ.
  - JALR: (rf_rdata1+immI) & ~1.
  - Taken branch: pc+immB; not taken: pc+4.
- Loads:
  - dmem_ren=1, dmem_addr=rf_rdata1+immI.
  - Byte lane = addr[1:0]; halfword lane = addr[1]; word ignores addr[1:0]. No misalignment trap.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - dmem_wen=1, dmem_addr=rf_rdata1+immS.
  - SB: wmask = 0001<<addr[1:0]; wdata = rs2[7:0] replicated to all 4 lanes.
  - SH: wmask = 0011<<(2*addr[1]); wdata = rs2[15:0] replicated to both halves.
  - SW: wmask = 1111; wdata = rs2.
- When not storing: dmem_wen=0, wmask=0.
- EBREAK or illegal (not halted):
  - ebreak/illegal asserted combinationally.
  - No register or memory write; pc_next=pc.
  - halted sets on the next rising edge.
- While halted=1:
  - rf_wen=0, dmem_wen=0, dmem_ren=0, pc_next=pc.
  - ebreak/illegal still reflect decode.
- rst asserted while halted clears halted immediately (asynchronous).

Test Plan:
- ADDI: inst=0x00500093, pc=0x80000000, rf_rdata1=0 -> rs1=0, rd=1, rf_wen=1, rf_wdata=5, pc_next=0x80000004, illegal=0.
- JAL: inst=0x008000EF, pc=0x80000000 -> rf_wdata=0x80000004, rf_wen=1, pc_next=0x80000008. BEQ x0,x0,+16: inst=0x00000863 -> pc_next=pc+16, rf_wen=0.
- LB: inst=0x00108103, rf_rdata1=0x80000100, dmem_rdata=0x00008000 -> dmem_addr=0x80000101, dmem_ren=1, rf_wdata=0xFFFFFF80. Same setup with LBU (funct3=100) -> rf_wdata=0x00000080.
- SB: inst=0x002081A3, rf_rdata1=0x80000100, rf_rdata2=0x000000AB -> dmem_addr=0x80000103, wmask=1000, dmem_wdata[31:24]=0xAB, dmem_wen=1, rf_wen=0.
- EBREAK: inst=0x00100073 -> ebreak=1, pc_next=pc, rf_wen=0. After the clock edge, halted=1. Then apply ADDI -> rf_wen=0, pc_next=pc. Pulse rst mid-cycle -> halted=0 without waiting for a clock edge.
- Illegal: inst=0x00000000 -> illegal=1, halted=1 after the next edge. With RF_ADDR_W=4, ADDI x16,x0,1 (0x00100813) -> illegal=1, rf_wen=0.
